ex_stage: RTL and testbench

Execute stage of the five-stage MIPS pipeline, directly downstream of instruction decode. Registers the decode bundle, runs the one-hot ALU, and issues the data-SRAM request for loads and stores. Feeds ALU results back to decode for forwarding and passes a registered-input bundle to the memory stage. Contains an iterative 32-cycle divider for `div`/`divu` that stalls the front of the pipeline while it runs.

---
 rtl/ex_stage_pkg.sv | 81 ++++++++
 rtl/ex_stage_div_iter.sv | 135 +++++++++++++
 rtl/ex_stage.sv | 167 ++++++++++++++++
 tb/tb_ex_stage.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage_pkg
//  Description : Shared widths, stall encodings, divide function codes, ALU
//                op bit positions and bus layouts for the execute stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package ex_stage_pkg;

  localparam int ID_TO_EX_WD  = 159;
  localparam int EX_TO_MEM_WD = 142;
  localparam int STALL_BUS_WD = 6;

  // Stall vector encodings: a set bit freezes the corresponding stage.
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // SPECIAL-opcode function codes for the divide instructions.
  localparam logic [5:0] OPCODE_SPECIAL = 6'h00;
  localparam logic [5:0] FUNCT_DIV      = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU     = 6'h1B;

  // One-hot alu_op bit positions.
  localparam int ALU_ADD  = 11;
  localparam int ALU_SUB  = 10;
  localparam int ALU_SLT  = 9;
  localparam int ALU_SLTU = 8;
  localparam int ALU_AND  = 7;
  localparam int ALU_NOR  = 6;
  localparam int ALU_OR   = 5;
  localparam int ALU_XOR  = 4;
  localparam int ALU_SLL  = 3;
  localparam int ALU_SRL  = 2;
  localparam int ALU_SRA  = 1;
  localparam int ALU_LUI  = 0;

  // Decode-to-execute bundle, MSB first.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  sel_alu_src1;
    logic [3:0]  sel_alu_src2;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
  } id_to_ex_t;

  // Execute-to-memory bundle, MSB first.
  typedef struct packed {
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi;
    logic [31:0] lo;
  } ex_to_mem_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // True for div/divu encodings.
  function automatic logic is_div_inst(input logic [31:0] inst);
    return (inst[31:26] == OPCODE_SPECIAL) &&
           ((inst[5:0] == FUNCT_DIV) || (inst[5:0] == FUNCT_DIVU));
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_stage_div_iter.sv
`default_nettype none
// ============================================================================
//  Module      : div_iter
//  Description : Iterative 32-step restoring divider with sign fix-up.
//                Compiled only when MIPS_DIV_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`ifdef MIPS_DIV_EN
module div_iter
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,      // divide instruction sitting in EX
  input  logic        signed_op_i,  // div (1) vs divu (0)
  input  logic [31:0] a_i,          // dividend
  input  logic [31:0] b_i,          // divisor
  input  logic        ack_i,        // EX may advance; leave DONE
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] q_o,
  output logic [31:0] r_o
);

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dsr_q, dsr_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;

  logic [31:0] w_a_abs;
  logic [31:0] w_b_abs;
  logic [32:0] w_rem_sh;
  logic [32:0] w_rem_sub;
  logic        w_ge;
  logic        w_b_zero;

  assign w_a_abs  = (signed_op_i && a_i[31]) ? (32'd0 - a_i) : a_i;
  assign w_b_abs  = (signed_op_i && b_i[31]) ? (32'd0 - b_i) : b_i;
  assign w_b_zero = (b_i == 32'd0);

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  assign w_rem_sh  = {rem_q, quo_q[31]};
  assign w_ge      = (w_rem_sh >= {1'b0, dsr_q});
  assign w_rem_sub = w_rem_sh - {1'b0, dsr_q};

  // State, counter and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= 5'd0;
      quo_q   <= 32'd0;
      rem_q   <= 32'd0;
      dsr_q   <= 32'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dsr_q   <= dsr_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    case (state_q)
      DIV_IDLE: begin
        if (start_i) begin
          cnt_d = 5'd0;
          if (w_b_zero) begin
            // Divide by zero: no iteration, fixed result pattern.
            rem_d   = a_i;
            quo_d   = 32'hFFFF_FFFF;
            dsr_d   = 32'd0;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            state_d = DIV_DONE;
          end else begin
            rem_d   = 32'd0;
            quo_d   = w_a_abs;
            dsr_d   = w_b_abs;
            qneg_d  = signed_op_i && (a_i[31] ^ b_i[31]);
            rneg_d  = signed_op_i && a_i[31];
            state_d = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        rem_d = w_ge ? w_rem_sub[31:0] : w_rem_sh[31:0];
        quo_d = {quo_q[30:0], w_ge};
        if (cnt_q == 5'd31) begin
          cnt_d   = 5'd0;
          state_d = DIV_DONE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      DIV_DONE: begin
        if (ack_i) begin
          state_d = DIV_IDLE;
        end
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  // Stall is raised from the capture cycle onward unless the divisor is zero.
  assign busy_o = (state_q == DIV_BUSY) ||
                  ((state_q == DIV_IDLE) && start_i && !w_b_zero);
  assign done_o = (state_q == DIV_DONE);
  assign q_o    = qneg_q ? (32'd0 - quo_q) : quo_q;
  assign r_o    = rneg_q ? (32'd0 - rem_q) : rem_q;

  // Remainder after a successful subtract is always below the divisor.
  logic w_unused;
  assign w_unused = w_rem_sub[32];

endmodule
`endif
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage
//  Description : MIPS execute stage. Registers the decode bundle, runs the
//                one-hot ALU, issues data-SRAM requests, forwards results to
//                decode and builds the bundle for the memory stage.
//                Define MIPS_DIV_EN to include the iterative divider.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_BUS_WD-1:0] stall,
  output logic                    stallreq_for_ex,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    ex_wreg,
  output logic [4:0]              ex_waddr,
  output logic [31:0]             ex_wdata,
  output logic                    ex_is_load
);

  logic [ID_TO_EX_WD-1:0] id_bus_q, id_bus_d;
  id_to_ex_t              id;

  // Input register next value: bubble, load, or hold.
  always_comb begin
    id_bus_d = id_bus_q;
    if ((stall[2] == STOP) && (stall[3] == NO_STOP)) begin
      id_bus_d = '0;
    end else if (stall[2] == NO_STOP) begin
      id_bus_d = id_to_ex_bus;
    end
  end

  // Input register.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_bus_q <= '0;
    end else begin
      id_bus_q <= id_bus_d;
    end
  end

  assign id = id_to_ex_t'(id_bus_q);

  // ---------------------------------------------------------------- ALU
  logic [31:0] w_src1;
  logic [31:0] w_src2;
  logic [31:0] w_imm_sext;
  logic [31:0] w_imm_zext;
  logic [4:0]  w_shamt;
  logic [31:0] w_alu_res;

  assign w_imm_sext = {{16{id.inst[15]}}, id.inst[15:0]};
  assign w_imm_zext = {16'd0, id.inst[15:0]};
  assign w_shamt    = w_src1[4:0];

  assign w_src1 = ({32{id.sel_alu_src1[0]}} & id.rdata1)
                | ({32{id.sel_alu_src1[1]}} & id.pc)
                | ({32{id.sel_alu_src1[2]}} & {27'd0, id.inst[10:6]});

  assign w_src2 = ({32{id.sel_alu_src2[0]}} & id.rdata2)
                | ({32{id.sel_alu_src2[1]}} & w_imm_sext)
                | ({32{id.sel_alu_src2[2]}} & 32'd8)
                | ({32{id.sel_alu_src2[3]}} & w_imm_zext);

  // OR together the result of every selected operation; no op selected yields 0.
  always_comb begin
    w_alu_res = 32'd0;
    if (id.alu_op[ALU_ADD])  w_alu_res = w_alu_res | (w_src1 + w_src2);
    if (id.alu_op[ALU_SUB])  w_alu_res = w_alu_res | (w_src1 - w_src2);
    if (id.alu_op[ALU_SLT])  w_alu_res = w_alu_res | {31'd0, ($signed(w_src1) < $signed(w_src2))};
    if (id.alu_op[ALU_SLTU]) w_alu_res = w_alu_res | {31'd0, (w_src1 < w_src2)};
    if (id.alu_op[ALU_AND])  w_alu_res = w_alu_res | (w_src1 & w_src2);
    if (id.alu_op[ALU_NOR])  w_alu_res = w_alu_res | ~(w_src1 | w_src2);
    if (id.alu_op[ALU_OR])   w_alu_res = w_alu_res | (w_src1 | w_src2);
    if (id.alu_op[ALU_XOR])  w_alu_res = w_alu_res | (w_src1 ^ w_src2);
    if (id.alu_op[ALU_SLL])  w_alu_res = w_alu_res | (w_src2 << w_shamt);
    if (id.alu_op[ALU_SRL])  w_alu_res = w_alu_res | (w_src2 >> w_shamt);
    if (id.alu_op[ALU_SRA])  w_alu_res = w_alu_res | 32'($signed(w_src2) >>> w_shamt);
    if (id.alu_op[ALU_LUI])  w_alu_res = w_alu_res | {w_src2[15:0], 16'd0};
  end

  // ---------------------------------------------------------------- HI/LO
  logic        w_hi_we;
  logic        w_lo_we;
  logic [31:0] w_hi;
  logic [31:0] w_lo;

`ifdef MIPS_DIV_EN
  logic        w_is_div;
  logic        w_div_signed;
  logic        w_div_busy;
  logic        w_div_done;
  logic [31:0] w_div_q;
  logic [31:0] w_div_r;

  assign w_is_div     = is_div_inst(id.inst);
  assign w_div_signed = (id.inst[5:0] == FUNCT_DIV);

  div_iter u_div_iter (
    .clk         (clk),
    .rst         (rst),
    .start_i     (w_is_div),
    .signed_op_i (w_div_signed),
    .a_i         (id.rdata1),
    .b_i         (id.rdata2),
    .ack_i       (stall[2] == NO_STOP),
    .busy_o      (w_div_busy),
    .done_o      (w_div_done),
    .q_o         (w_div_q),
    .r_o         (w_div_r)
  );

  assign stallreq_for_ex = w_div_busy;
  assign w_hi_we         = w_div_done;
  assign w_lo_we         = w_div_done;
  assign w_hi            = w_div_done ? w_div_r : 32'd0;
  assign w_lo            = w_div_done ? w_div_q : 32'd0;
`else
  assign stallreq_for_ex = 1'b0;
  assign w_hi_we         = 1'b0;
  assign w_lo_we         = 1'b0;
  assign w_hi            = 32'd0;
  assign w_lo            = 32'd0;
`endif

  // ---------------------------------------------------------------- outputs
  ex_to_mem_t w_out;

  assign w_out.pc           = id.pc;
  assign w_out.data_ram_en  = id.data_ram_en;
  assign w_out.data_ram_wen = id.data_ram_wen;
  assign w_out.sel_rf_res   = id.sel_rf_res;
  assign w_out.rf_we        = id.rf_we;
  assign w_out.rf_waddr     = id.rf_waddr;
  assign w_out.ex_result    = w_alu_res;
  assign w_out.hi_we        = w_hi_we;
  assign w_out.lo_we        = w_lo_we;
  assign w_out.hi           = w_hi;
  assign w_out.lo           = w_lo;

  assign ex_to_mem_bus   = w_out;

  assign data_sram_en    = id.data_ram_en;
  assign data_sram_wen   = id.data_ram_wen;
  assign data_sram_addr  = w_alu_res;
  assign data_sram_wdata = id.rdata2;

  assign ex_wreg         = id.rf_we;
  assign ex_waddr        = id.rf_waddr;
  assign ex_wdata        = w_alu_res;
  assign ex_is_load      = id.sel_rf_res;

  // Stall bits of other stages and instruction fields not decoded here.
  logic w_unused;
  assign w_unused = ^{stall[STALL_BUS_WD-1:4], stall[1:0], id.inst};

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_stage
//  Description : Directed self-checking bench for ex_stage. Divider vectors
//                are used when MIPS_DIV_EN is defined, otherwise the bench
//                checks that divides leave HI/LO untouched.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage;

  localparam logic [11:0] OP_ADD  = 12'h800;
  localparam logic [11:0] OP_SUB  = 12'h400;
  localparam logic [11:0] OP_SLT  = 12'h200;
  localparam logic [11:0] OP_SLTU = 12'h100;
  localparam logic [11:0] OP_AND  = 12'h080;
  localparam logic [11:0] OP_NOR  = 12'h040;
  localparam logic [11:0] OP_OR   = 12'h020;
  localparam logic [11:0] OP_XOR  = 12'h010;
  localparam logic [11:0] OP_SLL  = 12'h008;
  localparam logic [11:0] OP_SRL  = 12'h004;
  localparam logic [11:0] OP_SRA  = 12'h002;
  localparam logic [11:0] OP_LUI  = 12'h001;

  logic         clk;
  logic         rst;
  logic [5:0]   tb_stall;
  logic [5:0]   stall;
  logic         stallreq_for_ex;
  logic [158:0] id_to_ex_bus;
  logic [141:0] ex_to_mem_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         ex_wreg;
  logic [4:0]   ex_waddr;
  logic [31:0]  ex_wdata;
  logic         ex_is_load;

  int n_vec = 0;
  int n_err = 0;

  // Stall controller stand-in: a divider stall freezes IF..EX and bubbles MEM.
  assign stall = stallreq_for_ex ? 6'b001111 : tb_stall;

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .stallreq_for_ex (stallreq_for_ex),
    .id_to_ex_bus    (id_to_ex_bus),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .ex_wreg         (ex_wreg),
    .ex_waddr        (ex_waddr),
    .ex_wdata        (ex_wdata),
    .ex_is_load      (ex_is_load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [141:0] got, input logic [141:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [158:0] mk_id(
    input logic [31:0] pc, input logic [31:0] inst, input logic [11:0] op,
    input logic [2:0] s1, input logic [3:0] s2, input logic ram_en,
    input logic [3:0] wen, input logic rf_we, input logic [4:0] waddr,
    input logic sel_rf_res, input logic [31:0] rd1, input logic [31:0] rd2);
    return {pc, inst, op, s1, s2, ram_en, wen, rf_we, waddr, sel_rf_res, rd1, rd2};
  endfunction

  // Register-writing ALU instruction: checks forwarded data and the whole bus.
  task automatic alu_vec(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                         input logic [11:0] op, input logic [2:0] s1, input logic [3:0] s2,
                         input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] exp);
    id_to_ex_bus = mk_id(pc, inst, op, s1, s2, 1'b0, 4'h0, 1'b1, 5'd8, 1'b0, rd1, rd2);
    tick;
    check_eq({tag, "_wdata"}, ex_wdata, exp);
    check_eq({tag, "_bus"}, ex_to_mem_bus,
             {pc, 1'b0, 4'h0, 1'b0, 1'b1, 5'd8, exp, 66'd0});
  endtask

`ifdef MIPS_DIV_EN
  task automatic run_div(input string tag, input logic [5:0] funct, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    id_to_ex_bus = mk_id(32'hBFC0_0100, {6'h00, 5'd4, 5'd5, 10'd0, funct}, 12'h000,
                         3'b001, 4'b0001, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, a, b);
    tick;
    id_to_ex_bus = '0;
    cyc = 0;
    while (stallreq_for_ex && (cyc < 100)) begin
      cyc++;
      tick;
    end
    check_eq({tag, "_stall_cycles"}, cyc, 33);
    check_eq({tag, "_hi"}, ex_to_mem_bus[63:32], exp_hi);
    check_eq({tag, "_lo"}, ex_to_mem_bus[31:0], exp_lo);
    check_eq({tag, "_we"}, ex_to_mem_bus[65:64], 2'b11);
    // Held in DONE by an external stall: stable, no restart.
    tb_stall = 6'b001111;
    tick;
    check_eq({tag, "_hold_res"}, ex_to_mem_bus[65:0], {2'b11, exp_hi, exp_lo});
    check_eq({tag, "_hold_stallreq"}, stallreq_for_ex, 1'b0);
    tb_stall = 6'b000000;
    tick;
    check_eq({tag, "_release"}, {stallreq_for_ex, ex_to_mem_bus[65:64]}, 3'b000);
  endtask
`endif

  initial begin
    int cnt;
    rst          = 1'b1;
    tb_stall     = 6'b000000;
    id_to_ex_bus = mk_id(32'hBFC0_0000, 32'h3422_0034, OP_OR, 3'b001, 4'b1000,
                         1'b1, 4'hF, 1'b1, 5'd2, 1'b1, 32'h0000_1200, 32'h5);
    tick;
    tick;
    check_eq("reset_bus", ex_to_mem_bus, '0);
    check_eq("reset_stallreq", stallreq_for_ex, 1'b0);
    check_eq("reset_sram", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}, '0);
    check_eq("reset_fwd", {ex_wreg, ex_waddr, ex_wdata, ex_is_load}, '0);
    rst = 1'b0;

    // ori with zero-extended immediate.
    id_to_ex_bus = mk_id(32'hBFC0_0000, 32'h3422_0034, OP_OR, 3'b001, 4'b1000,
                         1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'h0000_1200, 32'h0);
    tick;
    check_eq("ori_wdata", ex_wdata, 32'h0000_1234);
    check_eq("ori_wreg", {ex_wreg, ex_waddr}, {1'b1, 5'd2});
    check_eq("ori_sram_en", data_sram_en, 1'b0);

    // Hold: stall[2] and stall[3] both Stop keep the previous instruction.
    tb_stall     = 6'b001111;
    id_to_ex_bus = mk_id(32'h1, 32'h0, OP_ADD, 3'b001, 4'b0001,
                         1'b1, 4'h3, 1'b0, 5'd7, 1'b0, 32'h1, 32'h1);
    tick;
    check_eq("hold_wdata", ex_wdata, 32'h0000_1234);
    check_eq("hold_ctrl", {ex_wreg, ex_waddr, data_sram_en}, {1'b1, 5'd2, 1'b0});

    // Bubble: stall[2] Stop with stall[3] NoStop.
    tb_stall = 6'b000111;
    tick;
    check_eq("bubble_ctrl", {ex_wreg, data_sram_en}, 2'b00);
    check_eq("bubble_bus", ex_to_mem_bus, '0);
    tb_stall = 6'b000000;

    alu_vec("addu_wrap", 32'hBFC0_0004, 32'h0000_0021, OP_ADD, 3'b001, 4'b0001, 32'hFFFF_FFFF, 32'h2, 32'h1);
    alu_vec("subu", 32'hBFC0_0008, 32'h0000_0023, OP_SUB, 3'b001, 4'b0001, 32'h5, 32'h7, 32'hFFFF_FFFE);
    alu_vec("slt", 32'hBFC0_000C, 32'h0000_002A, OP_SLT, 3'b001, 4'b0001, 32'hFFFF_FFFF, 32'h1, 32'h1);
    alu_vec("sltu", 32'hBFC0_0010, 32'h0000_002B, OP_SLTU, 3'b001, 4'b0001, 32'hFFFF_FFFF, 32'h1, 32'h0);
    alu_vec("slti_sext", 32'hBFC0_0014, 32'h2822_FFFF, OP_SLT, 3'b001, 4'b0010, 32'hFFFF_FFFE, 32'h0, 32'h1);
    alu_vec("and", 32'hBFC0_0018, 32'h0000_0024, OP_AND, 3'b001, 4'b0001, 32'hF0F0_FFFF, 32'h0FF0_F00F, 32'h00F0_F00F);
    alu_vec("nor", 32'hBFC0_001C, 32'h0000_0027, OP_NOR, 3'b001, 4'b0001, 32'h0, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    alu_vec("xor", 32'hBFC0_0020, 32'h0000_0026, OP_XOR, 3'b001, 4'b0001, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
    alu_vec("sll_sa", 32'hBFC0_0024, 32'h0002_1900, OP_SLL, 3'b100, 4'b0001, 32'h0, 32'h8000_0001, 32'h0000_0010);
    alu_vec("srl_sa", 32'hBFC0_0028, 32'h0002_1902, OP_SRL, 3'b100, 4'b0001, 32'h0, 32'h8000_0001, 32'h0800_0000);
    alu_vec("sra_sa", 32'hBFC0_002C, 32'h0002_1903, OP_SRA, 3'b100, 4'b0001, 32'h0, 32'h8000_0001, 32'hF800_0000);
    alu_vec("srav_reg", 32'hBFC0_0030, 32'h0002_1807, OP_SRA, 3'b001, 4'b0001, 32'h0000_0021, 32'h8000_0000, 32'hC000_0000);
    alu_vec("lui", 32'hBFC0_0034, 32'h3C02_ABCD, OP_LUI, 3'b000, 4'b1000, 32'h0, 32'h0, 32'hABCD_0000);
    alu_vec("pc_plus8", 32'hBFC0_0010, 32'h0C00_0000, OP_ADD, 3'b010, 4'b0100, 32'h0, 32'h0, 32'hBFC0_0018);
    alu_vec("no_op", 32'hBFC0_0038, 32'h0000_0000, 12'h000, 3'b001, 4'b0001, 32'h123, 32'h456, 32'h0);

    // sw: address from sign-extended offset, store data from rdata2.
    id_to_ex_bus = mk_id(32'hBFC0_0040, 32'hAC22_FFFC, OP_ADD, 3'b001, 4'b0010,
                         1'b1, 4'hF, 1'b0, 5'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
    tick;
    check_eq("sw_addr", data_sram_addr, 32'h0000_00FC);
    check_eq("sw_wdata", data_sram_wdata, 32'hDEAD_BEEF);
    check_eq("sw_ctrl", {data_sram_en, data_sram_wen, ex_wreg, ex_is_load}, {1'b1, 4'hF, 1'b0, 1'b0});

    // lw: load flag exported for load-use detection.
    id_to_ex_bus = mk_id(32'hBFC0_0044, 32'h8C29_0010, OP_ADD, 3'b001, 4'b0010,
                         1'b1, 4'h0, 1'b1, 5'd9, 1'b1, 32'h0000_2000, 32'h0);
    tick;
    check_eq("lw_addr", data_sram_addr, 32'h0000_2010);
    check_eq("lw_ctrl", {data_sram_en, data_sram_wen, ex_wreg, ex_waddr, ex_is_load},
             {1'b1, 4'h0, 1'b1, 5'd9, 1'b1});
    id_to_ex_bus = '0;
    tick;

`ifdef MIPS_DIV_EN
    run_div("div_m7_2", 6'h1A, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_div("div_7_m2", 6'h1A, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_div("divu_big", 6'h1B, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF);

    // divu by zero: no stall, DONE on the following cycle.
    id_to_ex_bus = mk_id(32'hBFC0_0200, {6'h00, 5'd4, 5'd5, 10'd0, 6'h1B}, 12'h000,
                         3'b001, 4'b0001, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'h5, 32'h0);
    tick;
    check_eq("divz_capture_stallreq", stallreq_for_ex, 1'b0);
    id_to_ex_bus = '0;
    tick;
    check_eq("divz_res", {stallreq_for_ex, ex_to_mem_bus[65:0]},
             {1'b0, 2'b11, 32'h0000_0005, 32'hFFFF_FFFF});
    tick;
    check_eq("divz_release", ex_to_mem_bus[65:64], 2'b00);

    // Reset during BUSY aborts the divide.
    id_to_ex_bus = mk_id(32'hBFC0_0300, {6'h00, 5'd4, 5'd5, 10'd0, 6'h1B}, 12'h000,
                         3'b001, 4'b0001, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'd100, 32'd7);
    tick;
    id_to_ex_bus = '0;
    for (int i = 0; i < 10; i++) tick;
    check_eq("rstbusy_pre", stallreq_for_ex, 1'b1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_eq("rstbusy_stallreq", stallreq_for_ex, 1'b0);
    check_eq("rstbusy_bus", ex_to_mem_bus, '0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (stallreq_for_ex || (ex_to_mem_bus[65:64] != 2'b00)) cnt++;
    end
    check_eq("rstbusy_no_result", cnt, 0);
`else
    // Without the divider a divide is a plain no-op: no stall, no HI/LO.
    id_to_ex_bus = mk_id(32'hBFC0_0100, {6'h00, 5'd4, 5'd5, 10'd0, 6'h1A}, 12'h000,
                         3'b001, 4'b0001, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'hFFFF_FFF9, 32'h2);
    tick;
    check_eq("nodiv_bus", ex_to_mem_bus, {32'hBFC0_0100, 110'd0});
    check_eq("nodiv_stallreq", stallreq_for_ex, 1'b0);
    id_to_ex_bus = '0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (stallreq_for_ex || (ex_to_mem_bus[65:0] != 66'd0)) cnt++;
    end
    check_eq("nodiv_quiet", cnt, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
